ifetch_queue: RTL
=================

# ifetch_queue

Instruction fetch front end. It holds the fetch program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their addresses in a DEPTH-entry FIFO. Decode pulls from the FIFO through a valid/ready handshake. It sits between the PC/next-PC logic (redirects from branch/jump resolution) and the decode stage, and is the consumer side of the program-counter interface.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- redirect_i  input  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req_o  output  1  read request valid
- imem_addr_o  output  32  word-aligned read address
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  read data valid
- imem_rdata_i  input  32  instruction word
- inst_valid_o  output  1  FIFO head valid
- inst_o  output  32  head instruction
- inst_pc_o  output  32  head instruction address
- inst_ready_i  input  1  decode accepts head

## Operation
- FSM states: IDLE, REQ, WAIT, DISCARD. At most one outstanding memory read.
- IDLE: go to REQ when count + 0 < DEPTH. After reset this is the first cycle after rst_i deasserts.
- REQ: imem_req_o=1 and imem_addr_o=fetch_pc. Both are held stable until imem_gnt_i. On grant: latch req_pc=fetch_pc, fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0), go to WAIT.
- WAIT: on imem_rvalid_i, push {req_pc, imem_rdata_i}. Then go to REQ if count_after_push < DEPTH, else IDLE.
- DISCARD: wait for imem_rvalid_i, drop the data, then go to REQ.
- Redirect (any state, highest priority):
  - Flush the FIFO (count=0, inst_valid_o=0 next cycle).
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - From IDLE or REQ without grant: go to REQ.
  - From REQ with imem_gnt_i in the same cycle: go to DISCARD.
  - From WAIT without rvalid: go to DISCARD.
  - From WAIT with rvalid in the same cycle: data dropped, go to REQ.
  - From DISCARD: stay in DISCARD unless rvalid, else REQ. fetch_pc is updated in every case.
- FIFO:
  - Pop when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle are allowed, including when full (count unchanged).
  - No push ever occurs when full.
  - Head outputs hold stable while inst_valid_o=1 and not popped.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_pc=RESET_PC, state=IDLE, count=0.
- First imem_req_o rises 1 cycle after reset release.
- Grant to next request: rvalid cycle + 1, i.e. one bubble cycle in WAIT→REQ. Memory rvalid arrives ≥1 cycle after grant.
- Redirect is sampled at the clock edge. imem_addr_o shows the new address the following cycle.
- Reset asserted mid-transaction: all state clears immediately. A late rvalid after reset release and before the first grant is ignored, because the FSM is not in WAIT or DISCARD.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the FIFO is empty and rvalid arrives in WAIT (no redirect), the response drives inst_valid_o/inst_o/inst_pc_o combinationally in the same cycle.
  - If inst_ready_i=1 that cycle, the entry is consumed and not written.
  - Fetch-to-decode latency is 0 cycles.
- IFQ_BYPASS_EN undefined:
  - All responses are written into the FIFO.
  - inst_valid_o rises 1 cycle after rvalid.
  - All head outputs are registered.

## Test plan
- Reset then free-running memory (gnt same cycle as req, rvalid 1 cycle later), inst_ready_i=1 -> inst_pc_o sequence 0x0, 0x4, 0x8, 0xC; inst_o matches memory words in order.
- inst_ready_i=0 with DEPTH=4 -> exactly 4 entries fill, imem_req_o stays 0 afterwards. Raising ready for 1 cycle pops 0x0 and triggers a new request.
- Redirect to 0x0000_0102 while in WAIT, rvalid arrives 3 cycles later -> response dropped, next imem_addr_o=0x0000_0100, first delivered inst_pc_o=0x100.
- Redirect in the same cycle as rvalid with 2 entries queued -> FIFO empty next cycle, no stale entry ever presented, fetch resumes at redirect address.
- redirect_pc_i=0xFFFF_FFFC -> delivered pcs 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- rst_i pulsed low while in WAIT, with rvalid asserted 1 cycle after release -> no push, first request at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Bundles the instruction-memory read bus, the redirect input and the decode handshake of ifetch_queue.
interface ifetch_queue_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    // master is the fetch queue; slave is the memory, decode and branch-resolution side
    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetch PC, single-outstanding imem reads, DEPTH-entry instruction FIFO.
// Defining IFQ_BYPASS_EN lets a response reach decode in the same cycle when the FIFO is empty.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ifetch_queue_if.master bus
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] { IDLE, REQ, WAIT, DISCARD } state_e;

    state_e           state_q;
    logic [31:0]      fetchPc_q;
    logic [31:0]      reqPc_q;
    logic [31:0]      instMem_q [DEPTH];
    logic [31:0]      pcMem_q   [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic        respValid;
    logic        headValid;
    logic        bypassHit;
    logic        pop;
    logic        fifoPop;
    logic        push;
    logic [31:0] redirectPc;

    assign redirectPc = {bus.redirect_pc_i[31:2], 2'b00};
    assign respValid  = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
    assign headValid  = (count_q != '0);

    assign bus.imem_req_o  = (state_q == REQ);
    assign bus.imem_addr_o = fetchPc_q;

`ifdef IFQ_BYPASS_EN
    // With an empty FIFO the response goes straight to decode; only a refused bypass gets stored
    assign bypassHit        = respValid && !headValid;
    assign bus.inst_valid_o = headValid || bypassHit;
    assign bus.inst_o       = bypassHit ? bus.imem_rdata_i : instMem_q[rdPtr_q];
    assign bus.inst_pc_o    = bypassHit ? reqPc_q : pcMem_q[rdPtr_q];
`else
    assign bypassHit        = 1'b0;
    assign bus.inst_valid_o = headValid;
    assign bus.inst_o       = instMem_q[rdPtr_q];
    assign bus.inst_pc_o    = pcMem_q[rdPtr_q];
`endif

    assign pop     = bus.inst_valid_o && bus.inst_ready_i;
    assign fifoPop = pop && !bypassHit;
    assign push    = respValid && !(bypassHit && bus.inst_ready_i);

    always_comb begin
        count_d = count_q;
        if (bus.redirect_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(fifoPop);
        end
    end

    // A redirect flushes the queue and retargets fetch; an in-flight read is drained in DISCARD
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            reqPc_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instMem_q[PTR_W'(i)] <= '0;
                pcMem_q[PTR_W'(i)]   <= '0;
            end
        end else begin
            count_q <= count_d;
            if (bus.redirect_i) begin
                rdPtr_q   <= '0;
                wrPtr_q   <= '0;
                fetchPc_q <= redirectPc;
                case (state_q)
                    REQ:           state_q <= bus.imem_gnt_i ? DISCARD : REQ;
                    WAIT, DISCARD: state_q <= bus.imem_rvalid_i ? REQ : DISCARD;
                    default:       state_q <= REQ;
                endcase
            end else begin
                if (fifoPop) begin
                    rdPtr_q <= rdPtr_q + PTR_W'(1);
                end
                if (push) begin
                    instMem_q[wrPtr_q] <= bus.imem_rdata_i;
                    pcMem_q[wrPtr_q]   <= reqPc_q;
                    wrPtr_q            <= wrPtr_q + PTR_W'(1);
                end
                case (state_q)
                    IDLE: begin
                        if (count_q < FULL_CNT) begin
                            state_q <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.imem_gnt_i) begin
                            reqPc_q   <= fetchPc_q;
                            fetchPc_q <= fetchPc_q + 32'd4;
                            state_q   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rvalid_i) begin
                            state_q <= (count_d < FULL_CNT) ? REQ : IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.imem_rvalid_i) begin
                            state_q <= REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
